// File: rtl/soil_moisture_sampler.sv
// Soil-moisture measurement front end.
// On a measurement request, this block triggers NSAMP ADC conversions and averages them.
// It applies a hysteresis threshold to the average and then signals completion to the
// controller FSM. A per-conversion timeout ensures that a silent ADC cannot stall the
// controller.
module soil_moisture_sampler #(
    parameter int ADC_W      = 10,
    parameter int NSAMP_LOG2 = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             meas_req,
    output logic             adc_start,
    input  logic             adc_valid,
    input  logic [ADC_W-1:0] adc_data,
    input  logic [ADC_W-1:0] thr_low,
    input  logic [ADC_W-1:0] thr_high,
    output logic             measurement_done,
    output logic             moisture_low,
    output logic [ADC_W-1:0] moisture_avg,
    output logic             busy,
    output logic             timeout_err
);

    localparam int ACC_W = ADC_W + NSAMP_LOG2;
    localparam int CNT_W = NSAMP_LOG2 + 1;
    localparam logic [CNT_W-1:0] NSAMP    = CNT_W'(1 << NSAMP_LOG2);
    localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0]      TMR_MAX  = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_WAIT    = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    state_e             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [15:0]        timer_q;
    logic               adc_start_q;
    logic               done_q;
    logic               moisture_low_q;
    logic [ADC_W-1:0]   moisture_avg_q;
    logic               busy_q;
    logic               timeout_err_q;

    logic [ACC_W-1:0]   acc_sum_d;
    logic [CNT_W-1:0]   cnt_inc_d;
    logic [ADC_W-1:0]   avg_d;
    logic [15:0]        timer_inc_d;

    // Datapath helpers: running sum, sample count, truncated mean, saturating timer.
    always_comb begin
        acc_sum_d   = acc_q + ACC_W'(adc_data);
        cnt_inc_d   = cnt_q + CNT_W'(1);
        avg_d       = acc_q[ACC_W-1:NSAMP_LOG2];
        if (timer_q == TMR_MAX) begin
            timer_inc_d = timer_q;
        end else begin
            timer_inc_d = timer_q + 16'd1;
        end
    end

    // Measurement sequencer. All outputs are registered and are set on entry to the
    // state in which they must be visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            acc_q          <= '0;
            cnt_q          <= '0;
            timer_q        <= 16'd0;
            adc_start_q    <= 1'b0;
            done_q         <= 1'b0;
            moisture_low_q <= 1'b0;
            moisture_avg_q <= '0;
            busy_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            adc_start_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    acc_q <= '0;
                    cnt_q <= '0;
                    if (meas_req) begin
                        state_q       <= S_START;
                        adc_start_q   <= 1'b1;
                        busy_q        <= 1'b1;
                        timeout_err_q <= 1'b0;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_START: begin
                    timer_q <= 16'd0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // A sample that arrives on the final timer cycle still counts.
                    if (adc_valid) begin
                        acc_q <= acc_sum_d;
                        cnt_q <= cnt_inc_d;
                        if (cnt_inc_d == NSAMP) begin
                            state_q <= S_COMPARE;
                        end else begin
                            state_q     <= S_START;
                            adc_start_q <= 1'b1;
                        end
                    end else if (timer_q >= TMO_LAST) begin
                        timeout_err_q <= 1'b1;
                        done_q        <= 1'b1;
                        state_q       <= S_DONE;
                    end else begin
                        timer_q <= timer_inc_d;
                    end
                end
                S_COMPARE: begin
                    moisture_avg_q <= avg_d;
                    // The low threshold wins if the two thresholds are inverted.
                    if (avg_d < thr_low) begin
                        moisture_low_q <= 1'b1;
                    end else if (avg_d > thr_high) begin
                        moisture_low_q <= 1'b0;
                    end else begin
                        moisture_low_q <= moisture_low_q;
                    end
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign adc_start        = adc_start_q;
    assign measurement_done = done_q;
    assign moisture_low     = moisture_low_q;
    assign moisture_avg     = moisture_avg_q;
    assign busy             = busy_q;
    assign timeout_err      = timeout_err_q;

endmodule
